sort_pack: RTL and testbench
============================

Name: sort_pack

Overview:
- Upstream packer for the 8-element nibble sorter.
- Accepts one 4-bit element per cycle over a valid/ready handshake and assembles N_ELEM elements into one packed word. Element 0 lands in the MSB slot.
- Presents the word with a valid/ready handshake to the combinational sorter input A, so the sorter sees only complete, stable words.

Parameters:
- N_ELEM, 8, number of elements per packed word (≥2).
- ELEM_W, 4, width of one element in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  block accepts an element this cycle.
- in_data  input  ELEM_W  element value.
- out_valid  output  1  out_word holds a complete word.
- out_ready  input  1  downstream accepts out_word this cycle.
- out_word  output  N_ELEM*ELEM_W  packed word; element k in bits [(N_ELEM-k)*ELEM_W-1 : (N_ELEM-k-1)*ELEM_W].
- fill_cnt  output  $clog2(N_ELEM+1)  number of elements currently held.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=FILL, out_valid=0, out_word=0, fill_cnt=0. in_ready=1 after reset deasserts.
- Transfer rule: a transfer happens on a rising edge where valid&&ready. No data-dependent combinational path from in_data to out_word.
- FSM states: FILL, HOLD.
- FILL:
  - in_ready=1, out_valid=0.
  - On accept, in_data is written to slot fill_cnt and fill_cnt increments.
  - Accepting element N_ELEM-1 moves to HOLD next cycle with out_valid=1 and fill_cnt=N_ELEM.
- HOLD:
  - out_valid=1. out_word is stable until the handshake.
  - in_ready=out_ready, which gives a zero-bubble pass-through.
  - out_ready=1 and in_valid=0: word drains, go to FILL, fill_cnt=0, word register cleared to 0.
  - out_ready=1 and in_valid=1 (simultaneous drain and accept): word drains. The new element is written to slot 0 with all other slots zeroed, fill_cnt=1, state=FILL.
  - out_ready=0: no element accepted; word and fill_cnt held.
- Throughput: one word per N_ELEM cycles under continuous valid/ready. First word is valid on the cycle after the N_ELEM-th accept (1-cycle latency from last element).
- Unused slots always read 0. 0 is the minimum value, so a descending sort places any zero padding in the low slots.
- in_valid is ignored while in_ready=0. The upstream must hold in_data and in_valid until accepted.
- Reset mid-word or mid-HOLD discards all content immediately, asynchronously. No partial word is emitted.

Optional Feature:
- Macro: SORT_PACK_FLUSH_EN.
- With the macro defined: adds input port flush (1 bit).
  - flush=1 in FILL with fill_cnt>0 forces HOLD next cycle. out_word holds the accepted elements with the remaining slots 0.
  - If in_valid is also accepted that cycle, the element is included before flushing.
  - flush with fill_cnt=0 and no accept is ignored.
  - flush in HOLD is ignored.
- Without the macro: no flush port. Words are emitted only when full.

Decomposition:
- Package sort_pkg:
  - localparams SORT_N_ELEM=8, SORT_ELEM_W=4, SORT_WORD_W=32.
  - typedef elem_t (logic [SORT_ELEM_W-1:0]).
  - typedef word_t (logic [SORT_WORD_W-1:0]).
  - enum pack_state_e {FILL, HOLD}.
- Sub-module: none required. The slot-write decoder stays inline. The FSM and counter are small enough that one module is clearest.

Test Plan:
- Continuous stream: in_data 1,2,3,4,5,6,7,8 back-to-back with out_ready=1 -> out_valid on the cycle after the 8th accept, out_word=32'h12345678, high for one cycle, then 0.
- Backpressure: full word 32'hF0E1D2C3 with out_ready=0 for 5 cycles -> out_word stable, in_ready=0, fill_cnt=8; at out_ready=1 the word drains once.
- Simultaneous drain and accept: in HOLD, out_ready=1 and in_valid=1 with data 4'hA -> next cycle out_valid=0, fill_cnt=1, out_word[31:28]=A, rest 0.
- Async reset: assert rst_n=0 between clock edges after 5 elements -> outputs zero immediately. After release, a fresh 8 elements 9,9,9,9,9,9,9,9 give 32'h99999999.
- Gapped input: in_valid toggling 1/0 with 8 elements 8..1 -> out_word=32'h87654321; fill_cnt steps by exactly 1 per accept.
- Flush (SORT_PACK_FLUSH_EN): accept 7,3,5 then flush -> out_word=32'h73500000, out_valid=1 next cycle; flush at fill_cnt=0 -> no output.

Source files
------------

// File: rtl/sort_pack_pkg.sv
// Shared types and sizing for the nibble sorter front end.
// Package name is sort_pkg; imported by sort_pack_if and sort_pack.
package sort_pkg;

    localparam int SORT_N_ELEM = 8;
    localparam int SORT_ELEM_W = 4;
    localparam int SORT_WORD_W = 32;

    typedef logic [SORT_ELEM_W-1:0] elem_t;
    typedef logic [SORT_WORD_W-1:0] word_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/sort_pack_if.sv
// Element-in / word-out bus for sort_pack. The master modport is the producer and
// sorter side; the slave modport is the packer.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both high.
// The sender holds data and valid stable until that edge. The receiver may change
// ready at any time. valid never depends combinationally on ready.
interface sort_pack_if
    import sort_pkg::*;
#(
    parameter int N_ELEM = SORT_N_ELEM,
    parameter int ELEM_W = SORT_ELEM_W
) ();

    localparam int WORD_W = N_ELEM * ELEM_W;
    localparam int CNT_W  = $clog2(N_ELEM + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [CNT_W-1:0]  fill_cnt;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  fill_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output fill_cnt
    );

endinterface

// File: rtl/sort_pack.sv
// Packs N_ELEM elements (element 0 in the MSB slot) into one word for the sorter.
// Optional SORT_PACK_FLUSH_EN adds a flush input that emits a partial word.
module sort_pack
    import sort_pkg::*;
#(
    parameter int N_ELEM = SORT_N_ELEM,
    parameter int ELEM_W = SORT_ELEM_W
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SORT_PACK_FLUSH_EN
    input  logic        flush,
`endif
    sort_pack_if.slave  bus,
    output pack_state_e state_o
);

    localparam int WORD_W = N_ELEM * ELEM_W;
    localparam int CNT_W  = $clog2(N_ELEM + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_ELEM - 1);

    pack_state_e       state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              flush_c;

`ifdef SORT_PACK_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    // Slot k occupies bits [(N_ELEM-k)*ELEM_W-1 -: ELEM_W].
                    for (int k = 0; k < N_ELEM; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            word_d[(N_ELEM-1-k)*ELEM_W +: ELEM_W] = bus.in_data;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SLOT) begin
                        state_d = HOLD;
                    end
                end
                if (flush_c && (cnt_q != '0 || bus.in_valid)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Drain; a same-cycle element starts the next word in slot 0.
                    state_d = FILL;
                    word_d  = '0;
                    cnt_d   = '0;
                    if (bus.in_valid) begin
                        word_d[WORD_W-1 -: ELEM_W] = bus.in_data;
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b1;
        out_valid_c = 1'b0;
        unique case (state_q)
            FILL: begin
                in_ready_c  = 1'b1;
                out_valid_c = 1'b0;
            end
            HOLD: begin
                in_ready_c  = bus.out_ready;
                out_valid_c = 1'b1;
            end
            default: begin
                in_ready_c  = 1'b1;
                out_valid_c = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_word  = word_q;
    assign bus.fill_cnt  = cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sort_pack.sv
// Directed bench for sort_pack; SORT_PACK_FLUSH_EN also enables the flush steps.
module tb_sort_pack;
    import sort_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    pack_state_e state_o;
    int          checks;
    int          errors;

    sort_pack_if #(.N_ELEM(8), .ELEM_W(4)) bus ();

    sort_pack #(.N_ELEM(8), .ELEM_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef SORT_PACK_FLUSH_EN
        .flush  (flush),
`endif
        .bus    (bus.slave),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [31:0] w,
                           input logic [3:0] cnt, input logic ir);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".out_word"}, bus.out_word, w);
        chk({tag, ".fill_cnt"}, 32'(bus.fill_cnt), 32'(cnt));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(ir));
    endtask

    // Present one element for exactly one rising edge, then drop valid.
    task automatic push(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [3:0] bp_vals [8];
    logic [3:0] gp_vals [8];

    initial begin
        checks = 0;
        errors = 0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        bp_vals = '{4'hF, 4'h0, 4'hE, 4'h1, 4'hD, 4'h2, 4'hC, 4'h3};
        gp_vals = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

        // Reset state
        #12;
        chk("rst.state", 32'(state_o), 32'(FILL));
        chk_out("rst", 1'b0, 32'h0, 4'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk_out("post_rst", 1'b0, 32'h0, 4'd0, 1'b1);

        // Continuous stream 1..8, out_ready high
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 4'(i + 1);
            @(posedge clk);
            @(negedge clk);
            if (i < 7) chk("stream.fill_cnt", 32'(bus.fill_cnt), 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        chk("stream.state", 32'(state_o), 32'(HOLD));
        chk_out("stream.word", 1'b1, 32'h12345678, 4'd8, 1'b1);
        idle(1);
        chk_out("stream.drain", 1'b0, 32'h0, 4'd0, 1'b1);

        // Backpressure: full word held 5 cycles, junk valid ignored while stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(bp_vals[i]);
        bus.in_valid = 1'b1;
        bus.in_data = 4'h5;
        for (int i = 0; i < 5; i++) begin
            chk_out("bp.hold", 1'b1, 32'hF0E1D2C3, 4'd8, 1'b0);
            idle(1);
        end
        bus.in_valid = 1'b0;
        chk_out("bp.hold_end", 1'b1, 32'hF0E1D2C3, 4'd8, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_comb", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        chk_out("bp.drain", 1'b0, 32'h0, 4'd0, 1'b1);
        idle(2);
        chk_out("bp.once", 1'b0, 32'h0, 4'd0, 1'b1);

        // Simultaneous drain and accept
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(4'(i + 1));
        chk_out("sim.hold", 1'b1, 32'h12345678, 4'd8, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'hA;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sim.state", 32'(state_o), 32'(FILL));
        chk_out("sim.next", 1'b0, 32'hA0000000, 4'd1, 1'b1);

        // Continue to 5 elements, then asynchronous reset between edges
        for (int i = 0; i < 4; i++) push(4'(i + 1));
        chk_out("ar.partial", 1'b0, 32'hA1234000, 4'd5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.state", 32'(state_o), 32'(FILL));
        chk_out("ar.async", 1'b0, 32'h0, 4'd0, 1'b1);
        @(negedge clk);
        chk_out("ar.held", 1'b0, 32'h0, 4'd0, 1'b1);
        rst_n = 1'b1;
        idle(1);
        bus.in_valid = 1'b1;
        bus.in_data = 4'h9;
        idle(8);
        bus.in_valid = 1'b0;
        chk_out("ar.fresh", 1'b1, 32'h99999999, 4'd8, 1'b1);
        idle(1);
        chk_out("ar.drain", 1'b0, 32'h0, 4'd0, 1'b1);

        // Gapped input 8..1, valid toggling
        for (int i = 0; i < 8; i++) begin
            push(gp_vals[i]);
            if (i < 7) begin
                chk("gap.cnt_accept", 32'(bus.fill_cnt), 32'(i + 1));
                idle(1);
                chk("gap.cnt_idle", 32'(bus.fill_cnt), 32'(i + 1));
            end
        end
        chk_out("gap.word", 1'b1, 32'h87654321, 4'd8, 1'b1);
        idle(1);
        chk_out("gap.drain", 1'b0, 32'h0, 4'd0, 1'b1);

`ifdef SORT_PACK_FLUSH_EN
        // Flush of a partial word
        bus.out_ready = 1'b0;
        push(4'h7);
        push(4'h3);
        push(4'h5);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk_out("fl.word", 1'b1, 32'h73500000, 4'd3, 1'b0);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk_out("fl.in_hold", 1'b1, 32'h73500000, 4'd3, 1'b0);
        bus.out_ready = 1'b1;
        idle(1);
        chk_out("fl.drain", 1'b0, 32'h0, 4'd0, 1'b1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk_out("fl.empty", 1'b0, 32'h0, 4'd0, 1'b1);
        // Flush together with an accept includes that element
        bus.out_ready = 1'b0;
        push(4'h6);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h2;
        idle(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk_out("fl.accept", 1'b1, 32'h62000000, 4'd2, 1'b0);
        bus.out_ready = 1'b1;
        idle(1);
        chk_out("fl.accept_drain", 1'b0, 32'h0, 4'd0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
